// File: rtl/stream_pkg.sv
// Shared definitions for the video stream generator: timing width, the
// RGB444 pixel layout and the frame-timing configuration record.
package stream_pkg;

  localparam int TIMING_W = 12;

  typedef logic [TIMING_W-1:0] timing_t;

  localparam timing_t TIMING_ONE  = 12'd1;
  localparam timing_t H_TOTAL_MIN = 12'd2;
  localparam timing_t V_TOTAL_MIN = 12'd1;

  // One pixel as it sits at the FIFO head: {R,G,B}, four bits each.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Frame timing in pixels/lines plus sync polarity inversion.
  typedef struct packed {
    timing_t h_total;
    timing_t h_sync;
    timing_t h_start;
    timing_t h_size;
    timing_t v_total;
    timing_t v_sync;
    timing_t v_start;
    timing_t v_size;
    logic    hs_inv;
    logic    vs_inv;
  } stream_cfg_t;

  // Degenerate totals would stall or underflow the counters; force the
  // smallest frame that still counts (2 pixels by 1 line).
  function automatic stream_cfg_t clamp_cfg(input stream_cfg_t c);
    stream_cfg_t r;
    r = c;
    if (c.h_total < H_TOTAL_MIN) r.h_total = H_TOTAL_MIN;
    if (c.v_total < V_TOTAL_MIN) r.v_total = V_TOTAL_MIN;
    return r;
  endfunction

  // start <= pos < start+size, with the end computed one bit wider so a
  // window running past 4095 does not wrap. A size of 0 never matches.
  function automatic logic in_window(input timing_t pos, input timing_t start,
                                     input timing_t size);
    logic [TIMING_W:0] stop;
    stop = {1'b0, start} + {1'b0, size};
    return ({1'b0, pos} >= {1'b0, start}) && ({1'b0, pos} < stop);
  endfunction

endpackage

// File: rtl/stream_timing.sv
// Horizontal/vertical position counters plus the shadow copy of the frame
// configuration. The shadow only refreshes between frames (or while the
// generator is stopped) so a half-drawn frame never sees new timing.
module stream_timing
  import stream_pkg::*;
(
  input  logic        i_pxl_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  stream_cfg_t live_cfg,
  output stream_cfg_t cur_cfg,
  output timing_t     h_cnt,
  output timing_t     v_cnt
);

  stream_cfg_t shadow_cfg;
  logic        shadow_valid;
  logic        line_end;
  logic        frame_end;
  logic        load;
  timing_t     h_last;
  timing_t     v_last;

  // Select the configuration in force this cycle and decide whether to reload.
  // Before the first load (right after reset) and while stopped, the live
  // inputs are used directly so the very first enabled cycle already runs
  // with the programmed timing.
  always_comb begin
    cur_cfg   = clamp_cfg((!i_enable || !shadow_valid) ? live_cfg : shadow_cfg);
    h_last    = cur_cfg.h_total - TIMING_ONE;
    v_last    = cur_cfg.v_total - TIMING_ONE;
    line_end  = (h_cnt == h_last);
    frame_end = line_end && (v_cnt == v_last);
    load      = !i_enable || !shadow_valid || frame_end;
  end

  // Shadow register: captured while stopped, on the first cycle after reset,
  // and on the last pixel of every frame.
  always_ff @(posedge i_pxl_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shadow_cfg   <= '0;
      shadow_valid <= 1'b0;
    end else if (load) begin
      shadow_cfg   <= live_cfg;
      shadow_valid <= 1'b1;
    end
  end

  // Raster counters: held at the origin while stopped, otherwise scan the frame.
  always_ff @(posedge i_pxl_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!i_enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == v_last) ? '0 : v_cnt + TIMING_ONE;
    end else begin
      h_cnt <= h_cnt + TIMING_ONE;
    end
  end

endmodule

// File: rtl/stream_gen.sv
// Video stream generator: scans a programmable raster, pulls pixels from a
// show-ahead FIFO during the active window and emits registered RGB/sync/DE.
//
// FIFO handshake: i_fifo_data is the current FIFO head and is valid whenever
// i_fifo_empty is low. o_fifo_next is the read acknowledge: the head is
// consumed on every rising i_pxl_clk edge where o_fifo_next is high, and
// o_fifo_next is only ever high while i_fifo_empty is low. An active pixel
// met with an empty FIFO is blanked to black and latched in o_underflow.
module stream_gen
  import stream_pkg::*;
#(
  parameter int SCR_SIZE_BIT = 11
) (
  input  logic                  i_pxl_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic [11:0]           i_h_total,
  input  logic [11:0]           i_h_sync,
  input  logic [11:0]           i_h_start,
  input  logic [11:0]           i_h_size,
  input  logic [11:0]           i_v_total,
  input  logic [11:0]           i_v_sync,
  input  logic [11:0]           i_v_start,
  input  logic [11:0]           i_v_size,
  input  logic                  i_HS_inv,
  input  logic                  i_VS_inv,
  input  logic [11:0]           i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_next,
  output logic                  o_line_req,
  output logic [SCR_SIZE_BIT:0] o_line_num,
  output logic [3:0]            o_R,
  output logic [3:0]            o_G,
  output logic [3:0]            o_B,
  output logic                  o_HS,
  output logic                  o_VS,
  output logic                  o_DE,
  output logic                  o_frame_start,
  input  logic                  i_clr_underflow,
  output logic                  o_underflow
);

  localparam int LN_W = SCR_SIZE_BIT + 1;

  stream_cfg_t live_cfg;
  stream_cfg_t cur_cfg;
  timing_t     h_cnt;
  timing_t     v_cnt;
  timing_t     next_v;
  timing_t     line_diff;
  rgb444_t     pix;
  logic        active;
  logic        line_end;
  logic        line_req;
  logic        hs_raw;
  logic        vs_raw;
  logic        at_origin;

  // Gather the timing inputs into one configuration record.
  always_comb begin
    live_cfg.h_total = i_h_total;
    live_cfg.h_sync  = i_h_sync;
    live_cfg.h_start = i_h_start;
    live_cfg.h_size  = i_h_size;
    live_cfg.v_total = i_v_total;
    live_cfg.v_sync  = i_v_sync;
    live_cfg.v_start = i_v_start;
    live_cfg.v_size  = i_v_size;
    live_cfg.hs_inv  = i_HS_inv;
    live_cfg.vs_inv  = i_VS_inv;
  end

  assign pix = rgb444_t'(i_fifo_data);

  stream_timing u_timing (
    .i_pxl_clk (i_pxl_clk),
    .i_reset_n (i_reset_n),
    .i_enable  (i_enable),
    .live_cfg  (live_cfg),
    .cur_cfg   (cur_cfg),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt)
  );

  // Decode the current raster position into window, sync and fetch events.
  // o_fifo_next is also gated by reset so nothing is popped while held in reset.
  always_comb begin
    active      = i_enable
                  && in_window(h_cnt, cur_cfg.h_start, cur_cfg.h_size)
                  && in_window(v_cnt, cur_cfg.v_start, cur_cfg.v_size);
    o_fifo_next = i_reset_n && active && !i_fifo_empty;
    line_end    = (h_cnt == cur_cfg.h_total - TIMING_ONE);
    next_v      = (v_cnt == cur_cfg.v_total - TIMING_ONE) ? '0 : v_cnt + TIMING_ONE;
    line_req    = i_enable && line_end
                  && in_window(next_v, cur_cfg.v_start, cur_cfg.v_size);
    line_diff   = next_v - cur_cfg.v_start;
    hs_raw      = i_enable && (h_cnt < cur_cfg.h_sync);
    vs_raw      = i_enable && (v_cnt < cur_cfg.v_sync);
    at_origin   = i_enable && (h_cnt == '0) && (v_cnt == '0);
  end

  // Output stage: everything leaves one cycle after the counter state it describes.
  always_ff @(posedge i_pxl_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_R           <= '0;
      o_G           <= '0;
      o_B           <= '0;
      o_DE          <= 1'b0;
      o_HS          <= 1'b0;
      o_VS          <= 1'b0;
      o_line_req    <= 1'b0;
      o_line_num    <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_R           <= o_fifo_next ? pix.r : 4'd0;
      o_G           <= o_fifo_next ? pix.g : 4'd0;
      o_B           <= o_fifo_next ? pix.b : 4'd0;
      o_DE          <= active;
      o_HS          <= hs_raw ^ cur_cfg.hs_inv;
      o_VS          <= vs_raw ^ cur_cfg.vs_inv;
      o_line_req    <= line_req;
      o_frame_start <= at_origin;
      if (line_req) o_line_num <= LN_W'(line_diff);
    end
  end

  // Sticky underflow flag; a new underflow beats a simultaneous clear.
  always_ff @(posedge i_pxl_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_underflow <= 1'b0;
    end else if (active && i_fifo_empty) begin
      o_underflow <= 1'b1;
    end else if (i_clr_underflow) begin
      o_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_gen.sv
// Bench for stream_gen: a frame-position reference model checks every cycle,
// table-driven whole-frame scenarios, hand sequences for corner cases, and a
// randomized run.
module tb_stream_gen;

  // ---------------- clock / reset / DUT ----------------
  logic        i_pxl_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [11:0] i_h_total, i_h_sync, i_h_start, i_h_size;
  logic [11:0] i_v_total, i_v_sync, i_v_start, i_v_size;
  logic        i_HS_inv, i_VS_inv;
  logic [11:0] i_fifo_data;
  logic        i_fifo_empty;
  logic        o_fifo_next;
  logic        o_line_req;
  logic [11:0] o_line_num;
  logic [3:0]  o_R, o_G, o_B;
  logic        o_HS, o_VS, o_DE, o_frame_start;
  logic        i_clr_underflow;
  logic        o_underflow;

  always #5 i_pxl_clk = ~i_pxl_clk;

  stream_gen #(.SCR_SIZE_BIT(11)) dut (
    .i_pxl_clk(i_pxl_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_h_total(i_h_total), .i_h_sync(i_h_sync), .i_h_start(i_h_start), .i_h_size(i_h_size),
    .i_v_total(i_v_total), .i_v_sync(i_v_sync), .i_v_start(i_v_start), .i_v_size(i_v_size),
    .i_HS_inv(i_HS_inv), .i_VS_inv(i_VS_inv),
    .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty), .o_fifo_next(o_fifo_next),
    .o_line_req(o_line_req), .o_line_num(o_line_num),
    .o_R(o_R), .o_G(o_G), .o_B(o_B), .o_HS(o_HS), .o_VS(o_VS), .o_DE(o_DE),
    .o_frame_start(o_frame_start),
    .i_clr_underflow(i_clr_underflow), .o_underflow(o_underflow)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks a single linear position p inside the frame; h and v are
  // derived from it by division. The config in force is copied from the inputs
  // at frame boundaries, while stopped, and on the first cycle after reset.
  typedef struct {
    int ht, hs, hst, hsz, vt, vs, vst, vsz;
    bit hinv, vinv;
  } mcfg_t;

  mcfg_t m_cfg;
  int    m_p = 0;
  bit    m_valid = 0;
  bit    m_uf = 0;
  int    m_ln = 0;

  // per-tick observations for scenario tallies
  int reg_p;
  int c_de, c_next, c_hs_low, c_vs_low;
  int de_line[16];
  int lreq_p[$];
  int lreq_n[$];
  logic [11:0] exp_q[$];

  function automatic mcfg_t live_cfg();
    mcfg_t c;
    c.ht = i_h_total; c.hs = i_h_sync; c.hst = i_h_start; c.hsz = i_h_size;
    c.vt = i_v_total; c.vs = i_v_sync; c.vst = i_v_start; c.vsz = i_v_size;
    c.hinv = i_HS_inv; c.vinv = i_VS_inv;
    return c;
  endfunction

  task automatic clear_stats();
    c_de = 0; c_next = 0; c_hs_low = 0; c_vs_low = 0;
    for (int i = 0; i < 16; i++) de_line[i] = 0;
    lreq_p.delete();
    lreq_n.delete();
  endtask

  // One clock cycle: predict from the inputs and model state, check the
  // combinational read strobe before the edge and all registered outputs after.
  task automatic tick();
    mcfg_t c;
    int H, V, h, v, nv;
    bit act, nxt, e_de, e_hs, e_vs, e_lreq, e_fs;
    logic [11:0] e_rgb;
    logic a_next;
    @(negedge i_pxl_clk);
    c = (!i_enable || !m_valid) ? live_cfg() : m_cfg;
    H = (c.ht < 2) ? 2 : c.ht;
    V = (c.vt < 1) ? 1 : c.vt;
    h = m_p % H;
    v = m_p / H;
    nv = (v + 1) % V;
    act = i_enable && (h >= c.hst) && (h < c.hst + c.hsz) && (v >= c.vst) && (v < c.vst + c.vsz);
    nxt = act && !i_fifo_empty;
    a_next = o_fifo_next;
    check("fifo_next", a_next, nxt);
    if (i_enable) begin
      e_de   = act;
      e_rgb  = nxt ? i_fifo_data : 12'h000;
      e_hs   = (h < c.hs) ^ c.hinv;
      e_vs   = (v < c.vs) ^ c.vinv;
      e_lreq = (h == H - 1) && (nv >= c.vst) && (nv < c.vst + c.vsz);
      e_fs   = (m_p == 0);
      if (e_lreq) m_ln = (nv - c.vst) & 32'hFFF;
      reg_p  = m_p;
    end else begin
      e_de = 0; e_rgb = 12'h000; e_hs = c.hinv; e_vs = c.vinv; e_lreq = 0; e_fs = 0;
      reg_p = -1;
    end
    if (act && i_fifo_empty) m_uf = 1;
    else if (i_clr_underflow) m_uf = 0;
    if (!i_enable) begin
      m_p = 0; m_cfg = live_cfg(); m_valid = 1;
    end else begin
      if (!m_valid) begin m_cfg = live_cfg(); m_valid = 1; end
      if (m_p == H * V - 1) begin m_p = 0; m_cfg = live_cfg(); end
      else m_p++;
    end
    @(posedge i_pxl_clk);
    #1;
    check("de", o_DE, e_de);
    check("rgb", {o_R, o_G, o_B}, e_rgb);
    check("hs", o_HS, e_hs);
    check("vs", o_VS, e_vs);
    check("line_req", o_line_req, e_lreq);
    check("line_num", o_line_num, m_ln);
    check("frame_start", o_frame_start, e_fs);
    check("underflow", o_underflow, m_uf);
    c_de     += (o_DE === 1'b1) ? 1 : 0;
    c_next   += (a_next === 1'b1) ? 1 : 0;
    c_hs_low += (o_HS === 1'b0) ? 1 : 0;
    c_vs_low += (o_VS === 1'b0) ? 1 : 0;
    if (o_DE === 1'b1 && reg_p >= 0 && reg_p / 10 < 16) de_line[reg_p / 10]++;
    if (o_line_req === 1'b1) begin
      lreq_p.push_back(reg_p);
      lreq_n.push_back(o_line_num);
    end
  endtask

  // Assert reset asynchronously, check the cleared outputs at once, release
  // just after the next rising edge.
  task automatic apply_reset(input string tag);
    i_reset_n = 1'b0;
    #1;
    check({tag, "_de"}, o_DE, 0);
    check({tag, "_rgb"}, {o_R, o_G, o_B}, 0);
    check({tag, "_hs"}, o_HS, 0);
    check({tag, "_vs"}, o_VS, 0);
    check({tag, "_lreq"}, o_line_req, 0);
    check({tag, "_lnum"}, o_line_num, 0);
    check({tag, "_fs"}, o_frame_start, 0);
    check({tag, "_uf"}, o_underflow, 0);
    check({tag, "_next"}, o_fifo_next, 0);
    m_p = 0; m_valid = 0; m_uf = 0; m_ln = 0;
    @(posedge i_pxl_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  task automatic set_default_cfg();
    i_h_total = 12'd10; i_h_sync = 12'd2; i_h_start = 12'd3; i_h_size = 12'd4;
    i_v_total = 12'd6;  i_v_sync = 12'd1; i_v_start = 12'd2; i_v_size = 12'd3;
    i_HS_inv = 1'b0; i_VS_inv = 1'b0;
    i_fifo_empty = 1'b0; i_clr_underflow = 1'b0; i_fifo_data = 12'h5A3;
  endtask

  // Stop for one cycle (loads the config, clears the flag), then run.
  task automatic restart();
    i_enable = 1'b0; i_clr_underflow = 1'b1;
    tick();
    i_clr_underflow = 1'b0; i_enable = 1'b1;
    clear_stats();
  endtask

  // Line requests at h=9 of lines 1,2,3 of a 10x6 frame, naming lines 0,1,2.
  task automatic check_line_reqs(input string tag);
    exp_q.delete();
    exp_q.push_back(12'd19); exp_q.push_back(12'd29); exp_q.push_back(12'd39);
    check({tag, "_lreq_count"}, lreq_p.size(), exp_q.size());
    for (int i = 0; i < 3 && i < lreq_p.size(); i++) begin
      check({tag, "_lreq_pos"}, lreq_p[i], exp_q[i]);
      check({tag, "_lreq_num"}, lreq_n[i], i);
    end
  endtask

  // ---------------- table-driven frame scenarios ----------------
  typedef struct {
    int hsz; bit hinv; bit vinv; bit empty;
    int de; int nxt; int hs_low; int vs_low; int lreq; bit uf;
  } row_t;

  row_t rows[4];

  initial begin
    set_default_cfg();
    apply_reset("reset");

    rows[0] = '{hsz:4, hinv:1, vinv:0, empty:0, de:12, nxt:12, hs_low:12, vs_low:50, lreq:3, uf:0};
    rows[1] = '{hsz:4, hinv:0, vinv:1, empty:1, de:12, nxt:0,  hs_low:48, vs_low:10, lreq:3, uf:1};
    rows[2] = '{hsz:0, hinv:0, vinv:0, empty:1, de:0,  nxt:0,  hs_low:48, vs_low:50, lreq:3, uf:0};
    rows[3] = '{hsz:7, hinv:1, vinv:1, empty:0, de:21, nxt:21, hs_low:12, vs_low:10, lreq:3, uf:0};

    for (int r = 0; r < 4; r++) begin
      set_default_cfg();
      i_h_size = 12'(rows[r].hsz); i_HS_inv = rows[r].hinv; i_VS_inv = rows[r].vinv;
      i_fifo_empty = rows[r].empty;
      restart();
      repeat (60) tick();
      check("tbl_de", c_de, rows[r].de);
      check("tbl_next", c_next, rows[r].nxt);
      check("tbl_hs_low", c_hs_low, rows[r].hs_low);
      check("tbl_vs_low", c_vs_low, rows[r].vs_low);
      check("tbl_lreq", lreq_p.size(), rows[r].lreq);
      check("tbl_uf", o_underflow, rows[r].uf);
    end

    // Full frame, FIFO never empty, inverted HS.
    set_default_cfg();
    i_HS_inv = 1'b1;
    restart();
    repeat (60) tick();
    for (int l = 0; l < 6; l++) check("frame_de_line", de_line[l], (l >= 2 && l <= 4) ? 4 : 0);
    check("frame_next_total", c_next, 12);
    check("frame_hs_low", c_hs_low, 12);
    check_line_reqs("frame");

    // Underflow on line 3, then clear, then set winning over a clear.
    set_default_cfg();
    i_fifo_data = 12'hABC;
    restart();
    for (int k = 0; k < 60; k++) begin
      i_fifo_empty = (m_p / 10 == 3);
      tick();
      if (reg_p == 33) check("uf_set", o_underflow, 1);
      if (reg_p == 34) begin
        check("uf_rgb_black", {o_R, o_G, o_B}, 0);
        check("uf_de_high", o_DE, 1);
      end
    end
    check("uf_held", o_underflow, 1);
    i_fifo_empty = 1'b0; i_clr_underflow = 1'b1;
    tick();
    check("uf_cleared", o_underflow, 0);
    for (int k = 1; k < 60; k++) begin
      i_fifo_empty = (m_p / 10 == 3);
      i_clr_underflow = (m_p / 10 == 3);
      tick();
      if (reg_p == 33) check("uf_set_wins", o_underflow, 1);
      if (reg_p == 37) check("uf_clr_after", o_underflow, 0);
    end
    i_fifo_empty = 1'b0; i_clr_underflow = 1'b0;

    // Mid-frame h_size change only takes effect on the next frame.
    set_default_cfg();
    restart();
    for (int k = 0; k < 60; k++) begin
      if (m_p == 30) i_h_size = 12'd6;
      tick();
    end
    check("cfg_old_de", c_de, 12);
    check("cfg_old_line4", de_line[4], 4);
    clear_stats();
    repeat (60) tick();
    check("cfg_new_de", c_de, 18);
    check("cfg_new_line2", de_line[2], 6);

    // Asynchronous reset in the middle of a frame at h=5, v=3.
    set_default_cfg();
    i_HS_inv = 1'b1;
    restart();
    for (int k = 0; k < 60 && m_p != 35; k++) begin
      i_fifo_empty = (m_p == 33);
      tick();
    end
    i_fifo_empty = 1'b0;
    check("pre_rst_de", o_DE, 1);
    check("pre_rst_uf", o_underflow, 1);
    #2;
    apply_reset("async_rst");
    tick();
    check("fs_after_rst", o_frame_start, 1);
    tick();
    check("fs_one_cycle", o_frame_start, 0);

    // Zero horizontal size: nothing active but line fetches continue.
    set_default_cfg();
    i_h_size = 12'd0; i_fifo_empty = 1'b1;
    restart();
    repeat (60) tick();
    check("hsz0_de", c_de, 0);
    check("hsz0_next", c_next, 0);
    check("hsz0_uf", o_underflow, 0);
    check_line_reqs("hsz0");

    // Randomized timing, enable, FIFO and clear activity against the model.
    set_default_cfg();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 9))
          0: i_h_total = 12'($urandom_range(0, 12));
          1: i_h_sync  = 12'($urandom_range(0, 12));
          2: i_h_start = 12'($urandom_range(0, 12));
          3: i_h_size  = 12'($urandom_range(0, 12));
          4: i_v_total = 12'($urandom_range(0, 8));
          5: i_v_sync  = 12'($urandom_range(0, 8));
          6: i_v_start = 12'($urandom_range(0, 8));
          7: i_v_size  = 12'($urandom_range(0, 8));
          8: i_HS_inv  = 1'($urandom_range(0, 1));
          default: i_VS_inv = 1'($urandom_range(0, 1));
        endcase
      end
      i_enable        = ($urandom_range(0, 19) != 0);
      i_fifo_empty    = ($urandom_range(0, 3) == 0);
      i_clr_underflow = ($urandom_range(0, 7) == 0);
      i_fifo_data     = 12'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        apply_reset("rand_rst");
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
